// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI register controller.
//   state_e        : frame sequencer states
//   CMD_WRITE_BIT  : command byte bit selecting write (1) or read (0)
//   *_PATTERN_DEF  : default transmit fill patterns
//   addr_inc()     : register address increment with wrap at num_regs-1
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ_FETCH,
    READ,
    DISCARD
  } state_e;

  localparam int         CMD_WRITE_BIT    = 7;
  localparam logic [7:0] IDLE_PATTERN_DEF = 8'hA5;
  localparam logic [7:0] ERR_PATTERN_DEF  = 8'hFF;

  function automatic logic [6:0] addr_inc(input logic [6:0] a, input int num_regs);
    return ({1'b0, a} == 8'(num_regs - 1)) ? 7'd0 : a + 7'd1;
  endfunction

endpackage

// File: rtl/spi_register_controller.sv
// Frame-level command sequencer between an SPI slave byte interface and a
// register bank. The first byte of a frame is a command (bit7 write, [6:0]
// start address); following bytes are write data or read dummies, with the
// address auto-incrementing and wrapping at NUM_REGS-1.
// Ports:
//   clk_in, reset_in        : clock, synchronous active-high reset
//   rx_byte/rx_ready        : received byte and its valid flag (level)
//   rx_ready_ack            : one-cycle acknowledge for each consumed byte
//   tx_byte                 : next MISO byte (idle / read data / error fill)
//   frame_end               : one-cycle pulse when nSS has risen and settled
//   reg_addr/reg_wdata      : register address and write data
//   reg_we/reg_re           : one-cycle write / read strobes
//   reg_rdata               : read data, valid one cycle after reg_re
//   frame_active            : high from command consumed until frame_end
//   err_count               : saturating count of invalid commands
module spi_register_controller
  import spi_ctrl_pkg::*;
#(
  parameter int         NUM_REGS     = 128,
  parameter logic [7:0] IDLE_PATTERN = IDLE_PATTERN_DEF,
  parameter logic [7:0] ERR_PATTERN  = ERR_PATTERN_DEF
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic [7:0] rx_byte,
  input  logic       rx_ready,
  output logic       rx_ready_ack,
  output logic [7:0] tx_byte,
  input  logic       frame_end,
  output logic [6:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       frame_active,
  output logic [7:0] err_count
);

  state_e state_q, state_d;
  logic   re_d;  // reg_rdata is valid while this is high

  // rx_ready is a level that stays up until acked; masking with the ack
  // register makes each byte count exactly once.
  logic consume;
  logic cmd_valid;
  logic cmd_wr;
  assign consume   = rx_ready & ~rx_ready_ack;
  assign cmd_valid = {1'b0, rx_byte[6:0]} < 8'(NUM_REGS);
  assign cmd_wr    = rx_byte[CMD_WRITE_BIT];

  // State register
  always_ff @(posedge clk_in) begin
    if (reset_in) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; frame_end overrides everything, including a byte
  // consumed in the same cycle.
  always_comb begin
    state_d = state_q;
    if (frame_end) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (consume) begin
          if (!cmd_valid)  state_d = DISCARD;
          else if (cmd_wr) state_d = WRITE;
          else             state_d = READ_FETCH;
        end
        READ_FETCH: if (re_d)    state_d = READ;
        READ:       if (consume) state_d = READ_FETCH;
        default:    state_d = state_q;
      endcase
    end
  end

  // Output decode: which datapath actions fire this cycle
  logic do_cmd, do_err, do_open, do_we, do_rd_next, do_re, do_cap;
  always_comb begin
    do_cmd     = (state_q == IDLE) && consume && !frame_end;
    do_err     = do_cmd && !cmd_valid;
    do_open    = do_cmd && cmd_valid;
    do_we      = (state_q == WRITE) && consume && !frame_end;
    do_rd_next = (state_q == READ) && consume && !frame_end;
    do_re      = (do_open && !cmd_wr) || do_rd_next;
    do_cap     = (state_q == READ_FETCH) && re_d && !frame_end;
  end

  // Registered datapath. Strobes already issued are not cancelled by
  // frame_end; the write-side increment rides on the reg_we cycle itself.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      rx_ready_ack <= 1'b0;
      reg_we       <= 1'b0;
      reg_re       <= 1'b0;
      re_d         <= 1'b0;
      reg_addr     <= '0;
      reg_wdata    <= '0;
      frame_active <= 1'b0;
      tx_byte      <= IDLE_PATTERN;
      err_count    <= '0;
    end else begin
      rx_ready_ack <= consume;
      reg_we       <= do_we;
      reg_re       <= do_re;
      re_d         <= reg_re;

      if (do_we) reg_wdata <= rx_byte;

      if (do_open)
        reg_addr <= rx_byte[6:0];
      else if (reg_we || do_rd_next)
        reg_addr <= addr_inc(reg_addr, NUM_REGS);

      if (frame_end) begin
        frame_active <= 1'b0;
        tx_byte      <= IDLE_PATTERN;
      end else begin
        if (do_cmd) frame_active <= 1'b1;
        if (do_err)      tx_byte <= ERR_PATTERN;
        else if (do_cap) tx_byte <= reg_rdata;
      end

      if (do_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule
